sensor_encoder: RTL and testbench

- Front end that produces the 2-bit sensor codes MS, CS and DS consumed by the Controller_module.
- Each of three raw 2-bit sensor inputs (M, C, D channels) is synchronised, legalised and debounced. The result is presented as a clean, glitch-free registered code.
- A one-cycle change strobe flags every code update, so the controller or a monitor can timestamp transitions.

---
 rtl/sensor_pkg.sv | 20 ++
 rtl/sensor_if.sv | 25 ++
 rtl/sensor_debounce.sv | 69 ++++++
 rtl/sensor_encoder.sv | 57 +++++
 tb/tb_sensor_encoder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared code map, default debounce settings and the ILLEGAL-code legaliser
// for the sensor front end.
package sensor_pkg;

  typedef logic [1:0] code_t;

  localparam code_t CODE_IDLE = 2'b00;
  localparam code_t CODE_REQ  = 2'b01;
  localparam code_t CODE_CFM  = 2'b10;
  localparam code_t CODE_ILL  = 2'b11;

  localparam int DB_CYCLES_DEFAULT = 4;
  localparam int CNT_W_DEFAULT     = 4;

  // ILLEGAL never propagates past the synchroniser; it reads as IDLE.
  function automatic code_t legalise(input code_t c);
    return (c == CODE_ILL) ? CODE_IDLE : c;
  endfunction

endpackage

// File: rtl/sensor_if.sv
// Raw sensor inputs, freeze control and debounced codes exchanged between the
// sensor front end and its environment.
interface sensor_if;
  import sensor_pkg::*;

  code_t m_raw;
  code_t c_raw;
  code_t d_raw;
  logic  freeze;
  code_t MS;
  code_t CS;
  code_t DS;
  logic  chg;

  modport master (
    output m_raw, c_raw, d_raw, freeze,
    input  MS, CS, DS, chg
  );

  modport slave (
    input  m_raw, c_raw, d_raw, freeze,
    output MS, CS, DS, chg
  );

endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchroniser, ILLEGAL->IDLE legaliser and a
// candidate/counter debouncer producing a registered, glitch-free code.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  code_t raw,
  input  logic  freeze,
  output code_t code,
  output logic  updated
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 15 || (1 << CNT_W) <= DB_CYCLES) begin : g_bad_params
    $error("sensor_debounce: DB_CYCLES must be 2..15 and fit in CNT_W bits");
  end

  code_t            s1;
  code_t            s2;
  code_t            cand;
  code_t            out;
  logic [CNT_W-1:0] cnt;
  code_t            legal;

  assign legal = legalise(s2);

  // The synchroniser keeps sampling while frozen so no stale data is resumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= CODE_IDLE;
      s2 <= CODE_IDLE;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= CODE_IDLE;
      cnt  <= '0;
      out  <= CODE_IDLE;
    end else if (!freeze) begin
      if (legal != cand) begin
        cand <= legal;
        cnt  <= '0;
      end else if (cand != out) begin
        if (cnt == CNT_LAST) begin
          out <= cand;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // High in the cycle whose closing edge loads a new value into out.
  assign updated = !freeze && (legal == cand) && (cand != out) && (cnt == CNT_LAST);
  assign code    = out;

endmodule

// File: rtl/sensor_encoder.sv
// Three independent debounced sensor channels (M, C, D) feeding the controller,
// plus a registered one-cycle strobe whenever any code changes.
module sensor_encoder
  import sensor_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input logic     clk,
  input logic     rst,
  sensor_if.slave bus
);

  logic upd_m;
  logic upd_c;
  logic upd_d;
  logic chg_q;

  sensor_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_m (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.m_raw),
    .freeze  (bus.freeze),
    .code    (bus.MS),
    .updated (upd_m)
  );

  sensor_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_c (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.c_raw),
    .freeze  (bus.freeze),
    .code    (bus.CS),
    .updated (upd_c)
  );

  sensor_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_d (
    .clk     (clk),
    .rst     (rst),
    .raw     (bus.d_raw),
    .freeze  (bus.freeze),
    .code    (bus.DS),
    .updated (upd_d)
  );

  // Simultaneous channel updates collapse into a single strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= !bus.freeze && (upd_m || upd_c || upd_d);
    end
  end

  assign bus.chg = chg_q;

endmodule

// File: tb/tb_sensor_encoder.sv
// Scoreboard bench for sensor_encoder: directed scenarios plus random raw
// traffic, checked every cycle against a behavioural debounce model.
module tb_sensor_encoder;
  localparam int DB = 4;

  typedef struct packed {
    logic [1:0] ms;
    logic [1:0] cs;
    logic [1:0] ds;
    logic       chg;
  } exp_t;

  logic clk = 1'b1;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sensor_if bus();

  sensor_encoder #(.DB_CYCLES(DB), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a value is accepted once the two-edge-delayed legal
  // sample has agreed with the pending candidate on DB unfrozen edges.
  logic [1:0] hist1 [3];
  logic [1:0] hist2 [3];
  logic [1:0] pend  [3];
  logic [1:0] acc   [3];
  int         agree [3];

  initial begin
    logic [1:0] raw_v [3];
    logic [1:0] seen;
    logic       changed;
    exp_t       e;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          hist1[k] = 2'b00; hist2[k] = 2'b00;
          pend[k]  = 2'b00; acc[k]   = 2'b00; agree[k] = 0;
        end
        exp_q.delete();
        exp_q.push_back('0);
      end else begin
        raw_v[0] = bus.m_raw; raw_v[1] = bus.c_raw; raw_v[2] = bus.d_raw;
        changed = 1'b0;
        for (int k = 0; k < 3; k++) begin
          seen = (hist2[k] == 2'b11) ? 2'b00 : hist2[k];
          hist2[k] = hist1[k];
          hist1[k] = raw_v[k];
          if (!bus.freeze) begin
            if (seen != pend[k]) begin
              pend[k]  = seen;
              agree[k] = 0;
            end else if (pend[k] == acc[k]) begin
              agree[k] = 0;
            end else begin
              agree[k] = agree[k] + 1;
              if (agree[k] == DB) begin
                acc[k]   = pend[k];
                agree[k] = 0;
                changed  = 1'b1;
              end
            end
          end
        end
        e.ms = acc[0]; e.cs = acc[1]; e.ds = acc[2]; e.chg = changed;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: checks each cycle on the falling edge; on an asynchronous reset
  // assertion it checks the outputs cleared immediately.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk or negedge rst);
      if (clk) begin
        #1;
        act = {bus.MS, bus.CS, bus.DS, bus.chg};
        n_tests++;
        if (act != '0) begin
          n_fail++;
          $display("FAIL async_reset t=%0t got MS=%b CS=%b DS=%b chg=%b want all zero",
                   $time, act.ms, act.cs, act.ds, act.chg);
        end
      end else if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.MS, bus.CS, bus.DS, bus.chg};
        n_tests++;
        if (act != e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got MS=%b CS=%b DS=%b chg=%b want MS=%b CS=%b DS=%b chg=%b",
                   $time, act.ms, act.cs, act.ds, act.chg, e.ms, e.cs, e.ds, e.chg);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic set_raw(input logic [1:0] m, input logic [1:0] c, input logic [1:0] d);
    bus.m_raw = m; bus.c_raw = c; bus.d_raw = d;
  endtask

  initial begin
    int hold;
    set_raw(2'b01, 2'b01, 2'b01);
    bus.freeze = 1'b0;
    #5 rst = 1'b0;
    #58 rst = 1'b1;
    step(10);

    // glitch rejection: 4-cycle pulse dropped, 5-cycle pulse accepted
    set_raw(2'b00, 2'b00, 2'b00);   step(10);
    bus.m_raw = 2'b10;              step(4);
    bus.m_raw = 2'b00;              step(10);
    bus.m_raw = 2'b10;              step(5);
    bus.m_raw = 2'b00;              step(10);

    // illegal code reads as idle
    bus.c_raw = 2'b01;              step(10);
    bus.c_raw = 2'b11;              step(10);

    // mid-count change restarts the count
    bus.d_raw = 2'b01;              step(3);
    bus.d_raw = 2'b10;              step(10);

    // simultaneous update, then freeze across a change
    set_raw(2'b00, 2'b00, 2'b00);   step(10);
    set_raw(2'b01, 2'b01, 2'b01);   step(10);
    bus.freeze = 1'b1;
    set_raw(2'b10, 2'b10, 2'b10);   step(8);
    bus.freeze = 1'b0;              step(10);

    // freeze in the middle of a count
    set_raw(2'b01, 2'b00, 2'b01);   step(4);
    bus.freeze = 1'b1;              step(3);
    bus.freeze = 1'b0;              step(10);

    // asynchronous reset mid-count, then full latency again
    set_raw(2'b10, 2'b01, 2'b00);   step(4);
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;                     step(12);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) bus.m_raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) bus.c_raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) bus.d_raw = 2'($urandom_range(0, 3));
      bus.freeze = ($urandom_range(0, 7) == 0);
      hold = int'($urandom_range(1, 8));
      step(hold);
    end
    bus.freeze = 1'b0;
    step(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
